spike_rate_decoder: RTL and testbench

Receiving end of the LIF neuron's spike output. Takes the raw spike line from the neuron, synchronises it, and detects rising edges. Over a programmable window it counts spikes and measures the last inter-spike interval (ISI). It returns the result to the controller through a valid/ready handshake. It sits between the tt_um_lif spike output pin and the digital readout logic.

---
 rtl/spike_rate_decoder_pkg.sv | 17 +
 rtl/spike_rate_decoder_sync_edge.sv | 33 +++
 rtl/spike_rate_decoder.sv | 161 ++++++++++++++++
 tb/tb_spike_rate_decoder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_rate_decoder_pkg.sv
// Shared types and constants for the spike rate decoder: FSM state encoding
// plus default widths and their saturation values.
package lif_pkg;

   localparam int CNT_W_DEF = 8;
   localparam int WIN_W_DEF = 16;

   localparam logic [CNT_W_DEF-1:0] CNT_MAX_DEF = '1;
   localparam logic [WIN_W_DEF-1:0] WIN_MAX_DEF = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      HOLD  = 2'd2
   } state_e;

endpackage

// File: rtl/spike_rate_decoder_sync_edge.sv
// Synchroniser for the asynchronous spike line followed by a rising-edge
// detector producing a single-cycle spk pulse.
module spike_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic spike_in,
   output logic sync,
   output logic spk
);

   if (SYNC_STAGES < 2) begin : g_bad_stages
      $error("spike_sync_edge needs at least two synchroniser stages");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], spike_in};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];
   assign spk  = sync & ~prev_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spikes and measures the last inter-spike interval over a programmable
// window, presenting each result through a valid/ready handshake.
module spike_rate_decoder
   import lif_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int WIN_W       = WIN_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             spike_in,
   input  logic             start,
   input  logic             continuous,
   input  logic [WIN_W-1:0] win_len,
   output logic [CNT_W-1:0] rate_out,
   output logic [WIN_W-1:0] isi_out,
   output logic             valid,
   input  logic             ready,
   output logic             busy,
   output logic             overflow,
   output logic             missed,
   output state_e           state_dbg
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [WIN_W-1:0] WIN_MAX = '1;
   localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

   // Handshake: a result is transferred on every rising clk edge where
   // valid & ready are both high; valid then drops (or a new window starts).

   logic spk;
   logic sync_unused;

   spike_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
      .clk      (clk),
      .rst      (rst),
      .spike_in (spike_in),
      .sync     (sync_unused),
      .spk      (spk)
   );

   state_e           state_q, state_d;
   logic [WIN_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIN_W-1:0] isi_run_q, isi_run_d;
   logic [WIN_W-1:0] isi_last_q, isi_last_d;
   logic             seen_q, seen_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] rate_q, rate_d;
   logic [WIN_W-1:0] isi_out_q, isi_out_d;
   logic             ovf_out_q, ovf_out_d;
   logic             valid_q, valid_d;
   logic             missed_q, missed_d;
   logic             load;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         cnt_q      <= '0;
         isi_run_q  <= '0;
         isi_last_q <= '0;
         seen_q     <= 1'b0;
         ovf_q      <= 1'b0;
         rate_q     <= '0;
         isi_out_q  <= '0;
         ovf_out_q  <= 1'b0;
         valid_q    <= 1'b0;
         missed_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         cnt_q      <= cnt_d;
         isi_run_q  <= isi_run_d;
         isi_last_q <= isi_last_d;
         seen_q     <= seen_d;
         ovf_q      <= ovf_d;
         rate_q     <= rate_d;
         isi_out_q  <= isi_out_d;
         ovf_out_q  <= ovf_out_d;
         valid_q    <= valid_d;
         missed_q   <= missed_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      cnt_d      = cnt_q;
      isi_run_d  = isi_run_q;
      isi_last_d = isi_last_q;
      seen_d     = seen_q;
      ovf_d      = ovf_q;
      rate_d     = rate_q;
      isi_out_d  = isi_out_q;
      ovf_out_d  = ovf_out_q;
      valid_d    = valid_q;
      missed_d   = missed_q;
      load       = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && ena && (win_len != '0)) load = 1'b1;
         end
         COUNT: begin
            if (ena) begin
               timer_d = timer_q - 1'b1;
               if (spk) begin
                  if (cnt_q == CNT_MAX) ovf_d = 1'b1;
                  else                  cnt_d = cnt_q + 1'b1;
                  // The interval is only defined from the second spike on.
                  if (seen_q) isi_last_d = (isi_run_q == WIN_MAX) ? WIN_MAX : isi_run_q + 1'b1;
                  isi_run_d = '0;
                  seen_d    = 1'b1;
               end else if (seen_q) begin
                  if (isi_run_q == WIN_MAX) ovf_d = 1'b1;
                  else                      isi_run_d = isi_run_q + 1'b1;
               end
               if (timer_q == WIN_ONE) begin
                  rate_d    = cnt_d;
                  isi_out_d = isi_last_d;
                  ovf_out_d = ovf_d;
                  valid_d   = 1'b1;
                  state_d   = HOLD;
               end
            end
         end
         HOLD: begin
            if (spk && ena) missed_d = 1'b1;
            if (ready) begin
               valid_d = 1'b0;
               if (continuous && (win_len != '0)) load = 1'b1;
               else                               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         timer_d    = win_len;
         cnt_d      = '0;
         isi_run_d  = '0;
         isi_last_d = '0;
         seen_d     = 1'b0;
         ovf_d      = 1'b0;
         state_d    = COUNT;
      end
   end

   assign rate_out  = rate_q;
   assign isi_out   = isi_out_q;
   assign overflow  = ovf_out_q;
   assign valid     = valid_q;
   assign missed    = missed_q;
   assign busy      = (state_q == COUNT);
   assign state_dbg = state_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: directed scenarios plus random traffic, checked
// against a window-level reference model through an expected-result queue.
`timescale 1ns/1ps
module tb_spike_rate_decoder;
   import lif_pkg::*;

   localparam int CNT_W = 8;
   localparam int WIN_W = 16;
   localparam int SYNC  = 2;
   localparam int RES_W = 1 + CNT_W + WIN_W;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             ena = 1'b0;
   logic             spike_in = 1'b0;
   logic             start = 1'b0;
   logic             continuous = 1'b0;
   logic             ready = 1'b0;
   logic [WIN_W-1:0] win_len = '0;
   logic [CNT_W-1:0] rate_out;
   logic [WIN_W-1:0] isi_out;
   logic             valid, busy, overflow, missed;
   state_e           state_dbg;

   int n_checks = 0;
   int n_pass   = 0;

   spike_rate_decoder #(.CNT_W(CNT_W), .WIN_W(WIN_W), .SYNC_STAGES(SYNC)) dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .spike_in   (spike_in),
      .start      (start),
      .continuous (continuous),
      .win_len    (win_len),
      .rate_out   (rate_out),
      .isi_out    (isi_out),
      .valid      (valid),
      .ready      (ready),
      .busy       (busy),
      .overflow   (overflow),
      .missed     (missed),
      .state_dbg  (state_dbg)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   // A window is the list of enabled-cycle indices at which an edge landed;
   // results are derived from that list when the window length is reached.
   typedef enum int {M_IDLE, M_COUNT, M_HOLD} mphase_t;
   mphase_t          m_phase = M_IDLE;
   int               m_win, m_elapsed;
   int               m_spikes[$];
   bit               m_missed = 1'b0;
   logic [SYNC+1:0]  s_hist = '0;
   logic [RES_W-1:0] exp_q[$];

   task automatic open_window();
      m_win     = int'(win_len);
      m_elapsed = 0;
      m_spikes.delete();
      m_phase   = M_COUNT;
   endtask

   task automatic close_window();
      int               n;
      logic [CNT_W-1:0] r;
      logic [WIN_W-1:0] isi;
      bit               ov;
      n   = m_spikes.size();
      ov  = (n > 255);
      r   = (n > 255) ? 8'd255 : n[CNT_W-1:0];
      isi = '0;
      if (n >= 2) isi = WIN_W'(m_spikes[n-1] - m_spikes[n-2]);
      exp_q.push_back({ov, r, isi});
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase  = M_IDLE;
         m_missed = 1'b0;
         s_hist   = '0;
         m_spikes.delete();
         exp_q.delete();
      end else begin
         bit spk_now;
         s_hist  = {s_hist[SYNC:0], spike_in};
         spk_now = s_hist[SYNC] & ~s_hist[SYNC+1];
         case (m_phase)
            M_IDLE: if (start && ena && win_len != 0) open_window();
            M_COUNT: if (ena) begin
               m_elapsed++;
               if (spk_now) m_spikes.push_back(m_elapsed);
               if (m_elapsed == m_win) begin
                  close_window();
                  m_phase = M_HOLD;
               end
            end
            M_HOLD: begin
               if (spk_now && ena) m_missed = 1'b1;
               if (ready) begin
                  if (continuous && win_len != 0) open_window();
                  else m_phase = M_IDLE;
               end
            end
            default: m_phase = M_IDLE;
         endcase
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (!rst) begin
         check("busy", busy, m_phase == M_COUNT);
         check("valid", valid, m_phase == M_HOLD);
         check("missed", missed, m_missed);
         if (valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL result_unexpected: got valid=1, want no result (t=%0t)", $time);
            end else begin
               check("rate_out", rate_out, exp_q[0][WIN_W +: CNT_W]);
               check("isi_out", isi_out, exp_q[0][WIN_W-1:0]);
               check("overflow", overflow, exp_q[0][RES_W-1]);
               if (ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   // ---------------- driver ----------------
   function automatic logic spike_pat(input int mode, input int c);
      case (mode)
         1: return (c >= 10 && c < 100 && ((c - 10) % 20) < 4);
         2: return (c < 990) && (c % 2 == 1);
         3: return (c == 18 || c == 20);
         4: return ($urandom_range(0, 3) == 0);
         default: return 1'b0;
      endcase
   endfunction

   // Pulses start for one cycle, then drives the pattern; lat counts edges
   // from the one sampling start up to the one that raised valid.
   task automatic run_window(input int wl, input int mode, input int ncyc, output int lat);
      win_len = WIN_W'(wl);
      start   = 1'b1;
      step();
      start   = 1'b0;
      lat     = -1;
      for (int c = 1; c <= ncyc; c++) begin
         spike_in = spike_pat(mode, c);
         step();
         if (valid && lat < 0) lat = c + 1;
      end
      spike_in = 1'b0;
   endtask

   task automatic handshake();
      ready = 1'b1;
      step();
      ready = 1'b0;
      step();
   endtask

   initial begin
      int lat;
      int waited;

      // reset state
      rst = 1'b1;
      repeat (3) step();
      check("rst_rate", rate_out, 0);
      check("rst_valid", valid, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      step();
      check("idle_state", state_dbg, IDLE);
      check("idle_isi", isi_out, 0);
      check("idle_overflow", overflow, 0);
      check("idle_missed", missed, 0);

      // start with a zero window is ignored
      ena     = 1'b1;
      win_len = '0;
      start   = 1'b1;
      repeat (5) step();
      start   = 1'b0;
      check("zero_win_busy", busy, 0);

      // five pulses at a 20-cycle period in a 100-cycle window
      run_window(100, 1, 110, lat);
      check("t2_latency", lat, 101);
      check("t2_rate", rate_out, 5);
      check("t2_isi", isi_out, 20);
      check("t2_overflow", overflow, 0);
      handshake();

      // count saturation
      run_window(1000, 2, 1010, lat);
      check("t3_latency", lat, 1001);
      check("t3_rate", rate_out, 255);
      check("t3_overflow", overflow, 1);
      check("t3_missed_clear", missed, 0);
      handshake();

      // edge in the final cycle counts; the next lands in HOLD
      run_window(20, 3, 30, lat);
      check("t4_latency", lat, 21);
      check("t4_rate", rate_out, 1);
      check("t4_isi", isi_out, 0);
      check("t4_missed", missed, 1);
      handshake();

      // continuous mode with back-pressure
      continuous = 1'b1;
      run_window(30, 4, 40, lat);
      check("t5_first_valid", valid, 1);
      repeat (10) step();
      check("t5_held_valid", valid, 1);
      ready = 1'b1;
      step();
      ready = 1'b0;
      check("t5_valid_drop", valid, 0);
      check("t5_busy_rise", busy, 1);
      waited = 0;
      while (!valid && waited < 100) begin
         spike_in = spike_pat(4, 0);
         step();
         waited++;
      end
      spike_in = 1'b0;
      check("t5_second_valid", valid, 1);
      continuous = 1'b0;
      handshake();

      // reset mid-window
      run_window(100, 4, 30, lat);
      rst = 1'b1;
      #1;
      check("t6_rate", rate_out, 0);
      check("t6_isi", isi_out, 0);
      check("t6_busy", busy, 0);
      check("t6_missed", missed, 0);
      repeat (2) step();
      rst = 1'b0;
      repeat (150) begin
         spike_in = spike_pat(4, 0);
         step();
      end
      spike_in = 1'b0;
      check("t6_state", state_dbg, IDLE);
      check("t6_no_valid", valid, 0);

      // random traffic
      repeat (2500) begin
         ena        = ($urandom_range(0, 9) != 0);
         spike_in   = ($urandom_range(0, 2) == 0);
         ready      = ($urandom_range(0, 2) != 0);
         continuous = $urandom_range(0, 1);
         start      = ($urandom_range(0, 3) == 0);
         win_len    = ($urandom_range(0, 12) == 0) ? '0 : WIN_W'($urandom_range(1, 40));
         step();
      end

      // drain
      ena        = 1'b1;
      spike_in   = 1'b0;
      start      = 1'b0;
      continuous = 1'b0;
      ready      = 1'b1;
      repeat (200) step();
      check("drain_queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
